// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: operand select plus a two-entry (main + skid) elastic buffer.
// Define ID_EX_FWD_EN to forward the EX/MEM result into rs1/rs2 at acceptance.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              use_pc_i,
  input  logic              use_imm_i,
  input  logic [3:0]        alu_op_i,
  input  logic [4:0]        rd_i,
  input  logic              fwd_valid_i,
  input  logic [4:0]        fwd_rd_i,
  input  logic [DATA_W-1:0] fwd_data_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [3:0]        op_o,
  output logic [4:0]        rd_o,
  output logic [DATA_W-1:0] pc_o
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] pc;
    logic [3:0]        op;
    logic [4:0]        rd;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state, state_nxt;
  entry_t            cap_p0, main_p1, skid_p1;
  logic [DATA_W-1:0] rs1_fwd, rs2_fwd;
  logic              accept, issue;

`ifdef ID_EX_FWD_EN
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [4:0]        addr,
                                                input logic [DATA_W-1:0] data);
    fwd_sel = (fwd_valid_i && (fwd_rd_i != 5'd0) && (fwd_rd_i == addr)) ? fwd_data_i : data;
  endfunction

  assign rs1_fwd = fwd_sel(rs1_addr_i, rs1_data_i);
  assign rs2_fwd = fwd_sel(rs2_addr_i, rs2_data_i);
`else
  // Forwarding compiled out: the bypass inputs stay on the port list but go nowhere.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid_i, fwd_rd_i, fwd_data_i, rs1_addr_i, rs2_addr_i};
  assign rs1_fwd    = rs1_data_i;
  assign rs2_fwd    = rs2_data_i;
`endif

  // Stage p0: operand selection for the entry presented this cycle
  always_comb begin
    cap_p0    = '0;
    cap_p0.a  = use_pc_i  ? pc_i  : rs1_fwd;
    cap_p0.b  = use_imm_i ? imm_i : rs2_fwd;
    cap_p0.pc = pc_i;
    cap_p0.op = alu_op_i;
    cap_p0.rd = rd_i;
  end

  assign accept = in_valid_i && in_ready_o;
  assign issue  = ex_valid_o && ex_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= EMPTY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) state_nxt = ONE;
        ONE: begin
          if (accept && !issue)      state_nxt = FULL;
          else if (!accept && issue) state_nxt = EMPTY;
        end
        FULL:    if (issue) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake flags come from state alone, never from inputs.
  always_comb begin
    in_ready_o = (state != FULL);
    ex_valid_o = (state != EMPTY);
  end

  // Stage p1: main/skid storage; a flush captures nothing
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else if (!flush_i) begin
      unique case (state)
        EMPTY: if (accept) main_p1 <= cap_p0;
        ONE: begin
          if (accept && issue) main_p1 <= cap_p0;
          else if (accept)     skid_p1 <= cap_p0;
        end
        FULL:    if (issue) main_p1 <= skid_p1;
        default: ;
      endcase
    end
  end

  assign a_o  = main_p1.a;
  assign b_o  = main_p1.b;
  assign op_o = main_p1.op;
  assign rd_o = main_p1.rd;
  assign pc_o = main_p1.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, capture, skid buffering, forwarding,
// operand select, streaming, flush and asynchronous reset.
module tb_id_ex_stage;

  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [4:0]        rs1_addr_i, rs2_addr_i;
  logic [DATA_W-1:0] rs1_data_i, rs2_data_i, imm_i, pc_i;
  logic              use_pc_i, use_imm_i;
  logic [3:0]        alu_op_i;
  logic [4:0]        rd_i;
  logic              fwd_valid_i;
  logic [4:0]        fwd_rd_i;
  logic [DATA_W-1:0] fwd_data_i;
  logic              flush_i;
  logic              ex_valid_o;
  logic              ex_ready_i;
  logic [DATA_W-1:0] a_o, b_o, pc_o;
  logic [3:0]        op_o;
  logic [4:0]        rd_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .pc_i(pc_i), .use_pc_i(use_pc_i), .use_imm_i(use_imm_i),
    .alu_op_i(alu_op_i), .rd_i(rd_i),
    .fwd_valid_i(fwd_valid_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i),
    .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .a_o(a_o), .b_o(b_o), .op_o(op_o), .rd_o(rd_o), .pc_o(pc_o)
  );

  // Advance one edge and settle just after it; inputs are changed right after this.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [4:0] rd, input logic [31:0] pc);
    in_valid_i  = v;
    rs1_data_i  = a;
    rs2_data_i  = b;
    alu_op_i    = op;
    rd_i        = rd;
    pc_i        = pc;
    rs1_addr_i  = 5'd1;
    rs2_addr_i  = 5'd2;
    imm_i       = '0;
    use_pc_i    = 1'b0;
    use_imm_i   = 1'b0;
    fwd_valid_i = 1'b0;
    fwd_rd_i    = '0;
    fwd_data_i  = '0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0);
    tick();
    n_cmp++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_ex_valid got %0b want 0", ex_valid_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %0b want 1", in_ready_o); end
    n_cmp++; if ({a_o, b_o, pc_o} !== '0) begin n_err++; $display("FAIL rst_data got a=%h b=%h pc=%h want 0", a_o, b_o, pc_o); end
    n_cmp++; if ({op_o, rd_o} !== 9'd0) begin n_err++; $display("FAIL rst_op_rd got op=%h rd=%0d want 0", op_o, rd_o); end
    rst_ni = 1'b1;
    tick();
    n_cmp++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL post_rst_ex_valid got %0b want 0", ex_valid_o); end
  endtask

  task automatic test_basic();
    ex_ready_i = 1'b0;
    drive(1'b1, 32'd5, 32'd7, 4'b0000, 5'd9, 32'h20);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0);
    n_cmp++; if (ex_valid_o !== 1'b1) begin n_err++; $display("FAIL basic_valid got %0b want 1", ex_valid_o); end
    n_cmp++; if (a_o !== 32'd5 || b_o !== 32'd7) begin n_err++; $display("FAIL basic_ab got a=%0d b=%0d want 5 7", a_o, b_o); end
    n_cmp++; if (op_o !== 4'b0000 || rd_o !== 5'd9 || pc_o !== 32'h20) begin n_err++; $display("FAIL basic_meta got op=%h rd=%0d pc=%h want 0 9 20", op_o, rd_o, pc_o); end
    ex_ready_i = 1'b1;
    tick();
    n_cmp++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_drain got %0b want 0", ex_valid_o); end
  endtask

  task automatic test_skid();
    ex_ready_i = 1'b0;
    drive(1'b1, 32'd1, 32'd0, 4'h1, 5'd1, 32'h0);
    tick();
    drive(1'b1, 32'd2, 32'd0, 4'h2, 5'd2, 32'h4);
    tick();
    n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL skid_full_ready got %0b want 0", in_ready_o); end
    n_cmp++; if (a_o !== 32'd1 || ex_valid_o !== 1'b1) begin n_err++; $display("FAIL skid_full_a got a=%0d v=%0b want 1 1", a_o, ex_valid_o); end
    drive(1'b1, 32'd3, 32'd0, 4'h3, 5'd3, 32'h8);
    tick();
    n_cmp++; if (a_o !== 32'd1 || in_ready_o !== 1'b0) begin n_err++; $display("FAIL skid_hold got a=%0d rdy=%0b want 1 0", a_o, in_ready_o); end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0);
    ex_ready_i = 1'b1;
    tick();
    n_cmp++; if (a_o !== 32'd2 || op_o !== 4'h2 || in_ready_o !== 1'b1 || ex_valid_o !== 1'b1) begin n_err++; $display("FAIL skid_promote got a=%0d op=%h rdy=%0b v=%0b want 2 2 1 1", a_o, op_o, in_ready_o, ex_valid_o); end
    tick();
    n_cmp++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL skid_drain got %0b want 0", ex_valid_o); end
  endtask

  task automatic test_forward();
    logic [31:0] exp_a;
    ex_ready_i = 1'b1;
    drive(1'b1, 32'h1111, 32'h2222, 4'h0, 5'd4, 32'h0);
    rs1_addr_i = 5'd3; fwd_valid_i = 1'b1; fwd_rd_i = 5'd3; fwd_data_i = 32'hDEAD;
`ifdef ID_EX_FWD_EN
    exp_a = 32'hDEAD;
`else
    exp_a = 32'h1111;
`endif
    tick();
    n_cmp++; if (a_o !== exp_a) begin n_err++; $display("FAIL fwd_hit got a=%h want %h", a_o, exp_a); end
    n_cmp++; if (b_o !== 32'h2222) begin n_err++; $display("FAIL fwd_b_untouched got b=%h want 2222", b_o); end
    drive(1'b1, 32'h3333, 32'h0, 4'h0, 5'd4, 32'h0);
    rs1_addr_i = 5'd0; fwd_valid_i = 1'b1; fwd_rd_i = 5'd0; fwd_data_i = 32'hBEEF;
    tick();
    n_cmp++; if (a_o !== 32'h3333) begin n_err++; $display("FAIL fwd_x0 got a=%h want 3333", a_o); end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0);
    tick();
  endtask

  task automatic test_pc_imm();
    ex_ready_i = 1'b0;
    drive(1'b1, 32'h5555, 32'h6666, 4'hF, 5'd31, 32'h100);
    use_pc_i = 1'b1; use_imm_i = 1'b1; imm_i = 32'hFFFF_FFFC;
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0);
    n_cmp++; if (a_o !== 32'h100 || b_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL pcimm_ab got a=%h b=%h want 100 fffffffc", a_o, b_o); end
    n_cmp++; if (op_o !== 4'hF || rd_o !== 5'd31 || pc_o !== 32'h100) begin n_err++; $display("FAIL pcimm_meta got op=%h rd=%0d pc=%h want f 31 100", op_o, rd_o, pc_o); end
    ex_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    ex_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(10 + i), 32'(20 + i), 4'(i + 6), 5'(i), 32'(i * 4));
      tick();
      n_cmp++; if (a_o !== 32'(10 + i) || b_o !== 32'(20 + i) || op_o !== 4'(i + 6) || ex_valid_o !== 1'b1 || in_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_%0d got a=%0d b=%0d op=%h v=%0b rdy=%0b want %0d %0d %h 1 1", i, a_o, b_o, op_o, ex_valid_o, in_ready_o, 10 + i, 20 + i, i + 6); end
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0);
    tick();
    n_cmp++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %0b want 0", ex_valid_o); end
  endtask

  task automatic test_flush();
    ex_ready_i = 1'b0;
    drive(1'b1, 32'd41, 32'd0, 4'h1, 5'd1, 32'h0);
    tick();
    drive(1'b1, 32'd42, 32'd0, 4'h2, 5'd2, 32'h0);
    tick();
    drive(1'b1, 32'h77, 32'd0, 4'h3, 5'd3, 32'h0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0);
    n_cmp++; if (ex_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_state got v=%0b rdy=%0b want 0 1", ex_valid_o, in_ready_o); end
    ex_ready_i = 1'b1;
    tick();
    n_cmp++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_no_entry got v=%0b want 0", ex_valid_o); end
    // flush in ONE together with an accept must also drop the new entry
    drive(1'b1, 32'd50, 32'd0, 4'h0, 5'd0, 32'h0);
    ex_ready_i = 1'b0;
    tick();
    drive(1'b1, 32'd51, 32'd0, 4'h0, 5'd0, 32'h0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0);
    n_cmp++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_one got v=%0b want 0", ex_valid_o); end
  endtask

  task automatic test_async_reset();
    ex_ready_i = 1'b0;
    drive(1'b1, 32'hAA, 32'hBB, 4'h3, 5'd7, 32'h40);
    tick();
    drive(1'b1, 32'hCC, 32'hDD, 4'h4, 5'd8, 32'h44);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0);
    n_cmp++; if (in_ready_o !== 1'b0 || a_o !== 32'hAA) begin n_err++; $display("FAIL areset_pre got rdy=%0b a=%h want 0 aa", in_ready_o, a_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++; if (ex_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin n_err++; $display("FAIL areset_flags got v=%0b rdy=%0b want 0 1", ex_valid_o, in_ready_o); end
    n_cmp++; if ({a_o, b_o, pc_o, op_o, rd_o} !== '0) begin n_err++; $display("FAIL areset_data got a=%h b=%h pc=%h op=%h rd=%0d want 0", a_o, b_o, pc_o, op_o, rd_o); end
    tick();
    #2 rst_ni = 1'b1;
    ex_ready_i = 1'b1;
    tick();
    n_cmp++; if (ex_valid_o !== 1'b0 || a_o !== 32'h0) begin n_err++; $display("FAIL areset_after got v=%0b a=%h want 0 0", ex_valid_o, a_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skid();
    test_forward();
    test_pc_imm();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter: DATA_W, 32, operand/result width.
REQ-002 The block SHALL have these ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  decode entry valid
- in_ready_o  out  1  stage can accept
- rs1_addr_i, rs2_addr_i  in  5 each  source register indices
- rs1_data_i, rs2_data_i  in  DATA_W each  register-file read data
- imm_i  in  DATA_W  sign-extended immediate
- pc_i  in  DATA_W  instruction PC
- use_pc_i  in  1  A operand = PC
- use_imm_i  in  1  B operand = immediate
- alu_op_i  in  4  ALU opcode (0000 add .. 1001 and)
- rd_i  in  5  destination register
- fwd_valid_i  in  1  EX/MEM result valid
- fwd_rd_i  in  5  EX/MEM destination
- fwd_data_i  in  DATA_W  EX/MEM result
- flush_i  in  1  synchronous pipeline flush
- ex_valid_o  out  1  ALU operands valid
- ex_ready_i  in  1  execute stage can consume
- a_o, b_o  out  DATA_W each  ALU operands a_i/b_i
- op_o  out  4  ALU op_i
- rd_o  out  5  destination passed to EX
- pc_o  out  DATA_W  PC passed to EX

Function
REQ-003 accept = in_valid_i && in_ready_o; issue = ex_valid_o && ex_ready_i; all transfers SHALL occur on the rising clk_i edge.
REQ-004 Storage SHALL be a main entry plus one skid entry; state SHALL be EMPTY, ONE or FULL.
REQ-005 in_ready_o SHALL be 1 iff state != FULL; ex_valid_o SHALL be 1 iff state != EMPTY; neither SHALL depend combinationally on any input.
REQ-006 EMPTY: accept -> ONE, main <= captured entry.
REQ-007 ONE: accept&&issue -> ONE, main <= captured; accept&&!issue -> FULL, skid <= captured; !accept&&issue -> EMPTY; else hold.
REQ-008 FULL: issue -> ONE, main <= skid; else hold; no accept possible.
REQ-009 a_o, b_o, op_o, rd_o, pc_o SHALL be driven directly from the main entry; held stable while ex_valid_o=1 and ex_ready_i=0.
REQ-010 Captured A = use_pc_i ? pc_i : rs1'; captured B = use_imm_i ? imm_i : rs2'; op, rd, pc captured unchanged.
REQ-011 rs1' = fwd_data_i when forwarding enabled, fwd_valid_i=1, fwd_rd_i != 0 and fwd_rd_i == rs1_addr_i, else rs1_data_i; rs2' identical with rs2_addr_i/rs2_data_i.
REQ-012 Forwarding SHALL be evaluated only at acceptance; stored entries SHALL NOT be updated afterwards.
REQ-013 Opcodes SHALL pass through unmodified, including undefined values 1010-1111.
REQ-014 Latency: accept in EMPTY -> ex_valid_o=1 next cycle; throughput one entry per cycle with ex_ready_i=1.
REQ-015 flush_i=1 SHALL force state EMPTY on that edge, discarding both entries and any same-cycle accept; issue in that cycle still counts as consumed by EX.

Reset
REQ-016 rst_ni=0 SHALL immediately force state EMPTY and clear both entries to zero, independent of clk_i.
REQ-017 During and after reset: ex_valid_o=0, in_ready_o=1, a_o=b_o=pc_o=0, op_o=0000, rd_o=0.
REQ-018 Reset asserted mid-transfer SHALL discard all held entries; no partial entry SHALL appear after release.

Configuration
REQ-019 Macro ID_EX_FWD_EN: defined -> forwarding per REQ-011; undefined -> rs1'=rs1_data_i, rs2'=rs2_data_i and fwd_* inputs ignored, ports retained.

Verification
REQ-020 Reset then accept rs1=5, rs2=7, op=0000, use_imm=0 -> next cycle ex_valid_o=1, a_o=5, b_o=7, op_o=0000.
REQ-021 ex_ready_i=0, push two entries (A=1, A=2) -> state FULL, in_ready_o=0, a_o=1; raise ex_ready_i -> a_o=1 issued, then a_o=2, in_ready_o=1.
REQ-022 Forwarding (macro defined): rs1_addr=3, fwd_valid=1, fwd_rd=3, fwd_data=0xDEAD -> a_o=0xDEAD; fwd_rd=0 -> a_o=rs1_data_i; macro undefined -> always rs1_data_i.
REQ-023 use_pc=1, pc=0x100, use_imm=1, imm=0xFFFFFFFC -> a_o=0x100, b_o=0xFFFFFFFC.
REQ-024 FULL state, flush_i=1 with in_valid_i=1 -> next cycle ex_valid_o=0, in_ready_o=1, no entry from that cycle appears.
REQ-025 rst_ni dropped mid-cycle while FULL -> ex_valid_o=0 without waiting for clk_i; all outputs zero.
